// File: rtl/mpc_cycle_state.sv
// mpc_cycle_state: mixed-precision cycle register (CSR 0x00D) with a
// committed shadow for setback recovery and a slice-descriptor FIFO to EX.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   setback_i           flush: restore committed cycle, empty the FIFO
//   commit_i            oldest dotp retired: shadow <= live cycle
//   ivec_fmt_i          current vector format
//   csr_we_i/wdata_i    software write to the cycle CSR
//   ctrl_we_i/next_i    controller cycle update (also pushes a descriptor)
//   current_cycle_o     live cycle back to the controller
//   desc_*              FIFO head (valid/ready, cycle, format, bit shift)
//   stall_o             FIFO full
//   ovf_err_o           sticky: push dropped because FIFO was full

package mpc_pkg;
  typedef enum logic [2:0] {
    NONE,
    MIXED_2x4,
    MIXED_2x8,
    MIXED_2x16,
    MIXED_4x8,
    MIXED_4x16,
    MIXED_8x16,
    FMT_OTHER
  } ivec_mode_fmt;
endpackage

module mpc_cycle_state
  import mpc_pkg::*;
#(
  parameter int NBITS_MIXED_CYCLES = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          setback_i,
  input  logic                          commit_i,
  input  ivec_mode_fmt                  ivec_fmt_i,
  input  logic                          csr_we_i,
  input  logic [NBITS_MIXED_CYCLES-1:0] csr_wdata_i,
  input  logic                          ctrl_we_i,
  input  logic [NBITS_MIXED_CYCLES-1:0] ctrl_next_cycle_i,
  output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
  output logic                          desc_valid_o,
  input  logic                          desc_ready_i,
  output logic [NBITS_MIXED_CYCLES-1:0] desc_cycle_o,
  output ivec_mode_fmt                  desc_fmt_o,
  output logic [4:0]                    desc_shift_o,
  output logic                          stall_o,
  output logic                          ovf_err_o
);

  localparam int NB = NBITS_MIXED_CYCLES;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = NB + 5;

  typedef struct packed {
    logic [NB-1:0] cyc;
    ivec_mode_fmt  fmt;
    logic [4:0]    shift;
  } desc_t;

  logic [NB-1:0] cycle_q, cycle_d;
  logic [NB-1:0] commit_q, commit_d;
  ivec_mode_fmt  fmt_q;
  logic          ovf_q;

  logic [NB-1:0] max_c;
  logic [4:0]    step;
  logic [NB-1:0] cyc_m;
  logic [PW-1:0] prod;

  desc_t         mem [FIFO_DEPTH];
  desc_t         head;
  desc_t         new_desc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, wr_en;

  // Highest cycle index and per-cycle bit offset (32 / ratio).
  always_comb begin
    max_c = '0;
    step  = '0;
    unique case (ivec_fmt_i)
      MIXED_2x4, MIXED_4x8, MIXED_8x16: begin
        max_c = NB'(1);
        step  = 5'd16;
      end
      MIXED_2x8, MIXED_4x16: begin
        max_c = NB'(3);
        step  = 5'd8;
      end
      MIXED_2x16: begin
        max_c = NB'(7);
        step  = 5'd4;
      end
      default: begin
        max_c = '0;
        step  = '0;
      end
    endcase
  end

  // Mask the outgoing cycle too, so a stale value left from a wider
  // format can never produce a shift outside the 32-bit word.
  assign cyc_m = cycle_q & max_c;
  assign prod  = PW'(cyc_m) * PW'(step);

  always_comb begin
    new_desc       = '0;
    new_desc.cyc   = cycle_q;
    new_desc.fmt   = ivec_fmt_i;
    new_desc.shift = prod[4:0];
  end

  always_comb begin
    cycle_d = cycle_q;
    if (setback_i)
      cycle_d = commit_q & max_c;
    else if (csr_we_i)
      cycle_d = csr_wdata_i & max_c;
    else if (ctrl_we_i)
      cycle_d = ctrl_next_cycle_i & max_c;
    else if (ivec_fmt_i != fmt_q)
      cycle_d = '0;
  end

  // CSR writes are architectural, so they land in the shadow directly.
  always_comb begin
    commit_d = commit_q;
    if (csr_we_i)
      commit_d = csr_wdata_i & max_c;
    else if (commit_i)
      commit_d = cycle_q;
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & desc_ready_i;
  assign push  = ctrl_we_i & ~setback_i;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      commit_q <= '0;
      fmt_q    <= NONE;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      commit_q <= commit_d;
      fmt_q    <= ivec_fmt_i;
      if (push & full & ~pop)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || setback_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)
        count <= count + CW'(1);
      else if (pop && !wr_en)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst && !setback_i)
      mem[wr_ptr] <= new_desc;
  end

  assign head = empty ? '0 : mem[rd_ptr];

  assign current_cycle_o = cycle_q;
  assign desc_valid_o    = ~empty;
  assign desc_cycle_o    = head.cyc;
  assign desc_fmt_o      = head.fmt;
  assign desc_shift_o    = head.shift;
  assign stall_o         = full;
  assign ovf_err_o       = ovf_q;

endmodule

// File: tb/tb_mpc_cycle_state.sv
// tb_mpc_cycle_state: directed table plus randomized run against a
// queue-based reference model of the cycle register and descriptor FIFO.
module tb_mpc_cycle_state;
  import mpc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         setback_i;
  logic         commit_i;
  ivec_mode_fmt ivec_fmt_i;
  logic         csr_we_i;
  logic [2:0]   csr_wdata_i;
  logic         ctrl_we_i;
  logic [2:0]   ctrl_next_cycle_i;
  logic [2:0]   current_cycle_o;
  logic         desc_valid_o;
  logic         desc_ready_i;
  logic [2:0]   desc_cycle_o;
  ivec_mode_fmt desc_fmt_o;
  logic [4:0]   desc_shift_o;
  logic         stall_o;
  logic         ovf_err_o;

  always #5 clk = ~clk;

  mpc_cycle_state dut (
    .clk               (clk),
    .rst               (rst),
    .setback_i         (setback_i),
    .commit_i          (commit_i),
    .ivec_fmt_i        (ivec_fmt_i),
    .csr_we_i          (csr_we_i),
    .csr_wdata_i       (csr_wdata_i),
    .ctrl_we_i         (ctrl_we_i),
    .ctrl_next_cycle_i (ctrl_next_cycle_i),
    .current_cycle_o   (current_cycle_o),
    .desc_valid_o      (desc_valid_o),
    .desc_ready_i      (desc_ready_i),
    .desc_cycle_o      (desc_cycle_o),
    .desc_fmt_o        (desc_fmt_o),
    .desc_shift_o      (desc_shift_o),
    .stall_o           (stall_o),
    .ovf_err_o         (ovf_err_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit rst, sb, cm;
    ivec_mode_fmt fmt;
    bit cwe; int cwd;
    bit we; int nx;
    bit rdy;
    int cyc; bit val; int dcyc; int dsh; bit st; bit ov;
  } vec_t;

  typedef struct {
    int c;
    ivec_mode_fmt f;
    int s;
  } mdesc_t;

  vec_t   tbl[$];
  mdesc_t mq[$];
  int     m_cyc, m_com;
  ivec_mode_fmt m_fmt;
  bit     m_ovf;

  function automatic int fmax(ivec_mode_fmt f);
    case (f)
      MIXED_2x4, MIXED_4x8, MIXED_8x16: return 1;
      MIXED_2x8, MIXED_4x16: return 3;
      MIXED_2x16: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock: model consumes current inputs, then compare.
  task automatic tick(string tag);
    int mx, nc, ncom, ratio;
    bit popm, was_full;
    mdesc_t d;
    mx   = fmax(ivec_fmt_i);
    popm = (mq.size() > 0) && desc_ready_i;
    if (rst) begin
      m_cyc = 0; m_com = 0; m_fmt = NONE; m_ovf = 0;
      mq.delete();
    end else begin
      ratio = mx + 1;
      d.c = m_cyc;
      d.f = ivec_fmt_i;
      d.s = (mx == 0) ? 0 : (m_cyc & mx) * (32 / ratio);
      if (setback_i)          nc = m_com & mx;
      else if (csr_we_i)      nc = int'(csr_wdata_i) & mx;
      else if (ctrl_we_i)     nc = int'(ctrl_next_cycle_i) & mx;
      else if (ivec_fmt_i != m_fmt) nc = 0;
      else                    nc = m_cyc;
      if (csr_we_i)      ncom = int'(csr_wdata_i) & mx;
      else if (commit_i) ncom = m_cyc;
      else               ncom = m_com;
      if (setback_i) mq.delete();
      else begin
        was_full = (mq.size() == 2);
        if (popm) void'(mq.pop_front());
        if (ctrl_we_i) begin
          if (was_full && !popm) m_ovf = 1;
          else mq.push_back(d);
        end
      end
      m_cyc = nc; m_com = ncom; m_fmt = ivec_fmt_i;
    end
    @(posedge clk);
    #1;
    chk({tag, " cycle"}, current_cycle_o, m_cyc);
    chk({tag, " valid"}, desc_valid_o, mq.size() > 0);
    chk({tag, " dcyc"}, desc_cycle_o, mq.size() > 0 ? mq[0].c : 0);
    chk({tag, " dfmt"}, desc_fmt_o, mq.size() > 0 ? mq[0].f : NONE);
    chk({tag, " dshift"}, desc_shift_o, mq.size() > 0 ? mq[0].s : 0);
    chk({tag, " stall"}, stall_o, mq.size() == 2);
    chk({tag, " ovf"}, ovf_err_o, m_ovf);
  endtask

  function automatic vec_t mk(bit r, bit sb, bit cm, ivec_mode_fmt f,
                              bit cwe, int cwd, bit we, int nx, bit rdy,
                              int cyc, bit val, int dcyc, int dsh,
                              bit st, bit ov);
    vec_t v;
    v.rst = r; v.sb = sb; v.cm = cm; v.fmt = f;
    v.cwe = cwe; v.cwd = cwd; v.we = we; v.nx = nx; v.rdy = rdy;
    v.cyc = cyc; v.val = val; v.dcyc = dcyc; v.dsh = dsh;
    v.st = st; v.ov = ov;
    return v;
  endfunction

  initial begin
    rst = 1; setback_i = 0; commit_i = 0; ivec_fmt_i = NONE;
    csr_we_i = 0; csr_wdata_i = 0; ctrl_we_i = 0;
    ctrl_next_cycle_i = 0; desc_ready_i = 0;
    m_cyc = 0; m_com = 0; m_fmt = NONE; m_ovf = 0;

    //            rst sb cm fmt        cwe d we nx rdy  cyc v dc dsh st ov
    tbl.push_back(mk(1,0,0,NONE,       0,0, 0,0, 0,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 0,0, 1,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 1,1, 1,   1,1,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 1,2, 1,   2,1,1, 8, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 1,3, 1,   3,1,2,16, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 1,0, 1,   0,1,3,24, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x8,  0,0, 0,0, 1,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x4,  0,0, 0,0, 1,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x4,  1,6, 0,0, 1,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 0,0, 1,   0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 1,6, 0,0, 1,   6,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,5, 1,   5,1,6,24, 0,0));
    tbl.push_back(mk(0,0,1,MIXED_2x16, 0,0, 0,0, 1,   5,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,6, 0,   6,1,5,20, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,7, 0,   7,1,5,20, 1,0));
    tbl.push_back(mk(0,1,0,MIXED_2x16, 0,0, 0,0, 0,   5,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,1, 0,   1,1,5,20, 0,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,2, 0,   2,1,5,20, 1,0));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,3, 0,   3,1,5,20, 1,1));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 1,4, 1,   4,1,1, 4, 1,1));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 0,0, 1,   4,1,3,12, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_2x16, 0,0, 0,0, 1,   4,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_4x16, 1,3, 0,0, 1,   3,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_8x16, 0,0, 0,0, 1,   0,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_4x16, 0,0, 0,0, 1,   0,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_4x16, 1,1, 0,0, 1,   1,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_4x16, 1,2, 1,1, 0,   2,1,1, 8, 0,1));
    tbl.push_back(mk(0,1,0,MIXED_4x16, 0,0, 0,0, 0,   2,0,0, 0, 0,1));
    tbl.push_back(mk(0,0,0,MIXED_4x16, 0,0, 1,3, 0,   3,1,2,16, 0,1));
    tbl.push_back(mk(1,1,0,MIXED_4x16, 1,1, 1,1, 0,   0,0,0, 0, 0,0));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      rst = tbl[i].rst; setback_i = tbl[i].sb; commit_i = tbl[i].cm;
      ivec_fmt_i = tbl[i].fmt;
      csr_we_i = tbl[i].cwe; csr_wdata_i = 3'(tbl[i].cwd);
      ctrl_we_i = tbl[i].we; ctrl_next_cycle_i = 3'(tbl[i].nx);
      desc_ready_i = tbl[i].rdy;
      tick(t);
      chk({t, " tbl_cycle"}, current_cycle_o, tbl[i].cyc);
      chk({t, " tbl_valid"}, desc_valid_o, tbl[i].val);
      chk({t, " tbl_dcyc"}, desc_cycle_o, tbl[i].dcyc);
      chk({t, " tbl_dshift"}, desc_shift_o, tbl[i].dsh);
      chk({t, " tbl_stall"}, stall_o, tbl[i].st);
      chk({t, " tbl_ovf"}, ovf_err_o, tbl[i].ov);
    end

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      setback_i = ($urandom_range(0, 15) == 0);
      commit_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        ivec_fmt_i = ivec_mode_fmt'(3'($urandom_range(0, 7)));
      csr_we_i = ($urandom_range(0, 9) == 0);
      csr_wdata_i = 3'($urandom_range(0, 7));
      ctrl_we_i = ($urandom_range(0, 1) == 0);
      ctrl_next_cycle_i = 3'($urandom_range(0, 7));
      desc_ready_i = ($urandom_range(0, 2) != 0);
      tick($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
